// File: rtl/pipe_pkg.sv
// Shared constants for the destination-register pipeline: default address width,
// architectural register numbers and the destination select encodings.
// No logic, so there is no latency or backpressure to describe.
package pipe_pkg;

   localparam int ADDR_W_DEF = 5;

   // Register 0 is hard-wired and never written; 31 is the link register.
   localparam int ZERO_REG = 0;
   localparam int LINK_REG = 31;

   // Destination select encodings: rt field, rd field, link register.
   localparam logic [1:0] SEL_RT   = 2'd0;
   localparam logic [1:0] SEL_RD   = 2'd1;
   localparam logic [1:0] SEL_LINK = 2'd2;

endpackage

// File: rtl/dest_stage.sv
// One pipeline slot holding a destination register address and its write enable.
// Latency: 1 cycle from d_* to q_*.
// Backpressure: stall holds the slot; flush empties it; rst has priority over both.
module dest_stage
   import pipe_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_we,
   output logic [ADDR_W-1:0] q_addr,
   output logic              q_we
);

   // Slot update in priority order: reset, flush to a bubble, hold on stall, else load.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_addr <= ADDR_W'(ZERO_REG);
         q_we   <= 1'b0;
      end else if (flush) begin
         q_addr <= ADDR_W'(ZERO_REG);
         q_we   <= 1'b0;
      end else if (!stall) begin
         q_addr <= d_addr;
         q_we   <= d_we;
      end
   end

endmodule

// File: rtl/dest_reg_pipe.sv
// Selects the write-back register from NUM_SRC candidates and carries it to write-back, flagging RAW hazards.
// Latency: DEPTH cycles from decode to wb_*, plus one cycle per stall cycle; hazard is combinational.
// Backpressure: stall freezes every stage and drops the input; flush turns the younger stages into bubbles.
module dest_reg_pipe
   import pipe_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int NUM_SRC = 3,
   parameter int DEPTH   = 3,
   parameter int SEL_W   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [SEL_W-1:0]          sel,
   input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
   input  logic                      in_valid,
   input  logic                      reg_write,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [2*ADDR_W-1:0]       query_addr,
   output logic [DEPTH*ADDR_W-1:0]   stage_addr,
   output logic [DEPTH-1:0]          stage_we,
   output logic [ADDR_W-1:0]         wb_addr,
   output logic                      wb_we,
   output logic [1:0]                hazard
);

   logic [ADDR_W-1:0] mux_addr;
   logic              sel_legal;
   logic              mux_we;
   logic [ADDR_W-1:0] entry_addr;
   logic              entry_we;

   // Destination mux; a select with no matching source yields address 0 and no write.
   always_comb begin
      mux_addr  = ADDR_W'(ZERO_REG);
      sel_legal = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == SEL_W'(i)) begin
            mux_addr  = src_addr[i*ADDR_W +: ADDR_W];
            sel_legal = 1'b1;
         end
      end
      mux_we = in_valid & reg_write & sel_legal & (mux_addr != ADDR_W'(ZERO_REG));
   end

   // A flushed decode slot enters as a bubble; this is the only flush effect when DEPTH is 1.
   always_comb begin
      entry_addr = flush ? ADDR_W'(ZERO_REG) : mux_addr;
      entry_we   = flush ? 1'b0 : mux_we;
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic [ADDR_W-1:0] d_addr;
      logic              d_we;
      logic              stage_flush;

      if (g == 0) begin : g_first
         assign d_addr = entry_addr;
         assign d_we   = entry_we;
      end else begin : g_chain
         assign d_addr = stage_addr[(g-1)*ADDR_W +: ADDR_W];
         assign d_we   = stage_we[g-1];
      end

      // The write-back stage is never flushed: the oldest instruction is already committed.
      if (g == DEPTH-1) begin : g_last
         assign stage_flush = 1'b0;
      end else begin : g_young
         assign stage_flush = flush;
      end

      dest_stage #(
         .ADDR_W (ADDR_W)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .flush  (stage_flush),
         .stall  (stall),
         .d_addr (d_addr),
         .d_we   (d_we),
         .q_addr (stage_addr[g*ADDR_W +: ADDR_W]),
         .q_we   (stage_we[g])
      );
   end

   assign wb_addr = stage_addr[(DEPTH-1)*ADDR_W +: ADDR_W];
   assign wb_we   = stage_we[DEPTH-1];

   // Hazard per query operand: any live in-flight write to the same register.
   always_comb begin
      hazard = 2'b00;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (stage_we[i] && (stage_addr[i*ADDR_W +: ADDR_W] == query_addr[k*ADDR_W +: ADDR_W])) begin
               hazard[k] = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Bench for dest_reg_pipe: directed scenarios followed by random traffic, checked by a scoreboard.
// Expected state is pushed by the driver each cycle and popped by a monitor after the clock edge.
// No backpressure beyond the stall/flush inputs driven here.
module tb_dest_reg_pipe;

   localparam int AW = 5;
   localparam int NS = 3;
   localparam int DP = 3;
   localparam int SW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [SW-1:0]     sel;
   logic [NS*AW-1:0]  src_addr;
   logic              in_valid;
   logic              reg_write;
   logic              stall;
   logic              flush;
   logic [2*AW-1:0]   query_addr;
   logic [DP*AW-1:0]  stage_addr;
   logic [DP-1:0]     stage_we;
   logic [AW-1:0]     wb_addr;
   logic              wb_we;
   logic [1:0]        hazard;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dest_reg_pipe #(.ADDR_W(AW), .NUM_SRC(NS), .DEPTH(DP), .SEL_W(SW)) dut (
      .clk        (clk),
      .rst        (rst),
      .sel        (sel),
      .src_addr   (src_addr),
      .in_valid   (in_valid),
      .reg_write  (reg_write),
      .stall      (stall),
      .flush      (flush),
      .query_addr (query_addr),
      .stage_addr (stage_addr),
      .stage_we   (stage_we),
      .wb_addr    (wb_addr),
      .wb_we      (wb_we),
      .hazard     (hazard)
   );

   typedef struct {
      logic [DP*AW-1:0] sa;
      logic [DP-1:0]    swe;
      logic [AW-1:0]    wa;
      logic             wwe;
      logic [1:0]       hz;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: an ordered list of in-flight writes, index 0 youngest.
   int m_addr[DP];
   bit m_we[DP];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs and record what the DUT must show after the next edge.
   task automatic step(input bit r, input int s, input logic [NS*AW-1:0] src,
                       input bit v, input bit w, input bit st, input bit fl,
                       input logic [2*AW-1:0] q);
      int n_addr[DP];
      bit n_we[DP];
      int e_addr;
      bit e_we;
      exp_t e;
      logic [NS*AW-1:0] srcv;
      logic [2*AW-1:0]  qv;
      @(negedge clk);
      rst = r; sel = SW'(s); src_addr = src; in_valid = v; reg_write = w;
      stall = st; flush = fl; query_addr = q;
      srcv = src;
      qv = q;
      if (s < NS) e_addr = int'(srcv[s*AW +: AW]);
      else        e_addr = 0;
      e_we = v && w && (s < NS) && (e_addr != 0);
      for (int i = 0; i < DP; i++) begin
         n_addr[i] = m_addr[i];
         n_we[i]   = m_we[i];
      end
      if (r) begin
         for (int i = 0; i < DP; i++) begin n_addr[i] = 0; n_we[i] = 0; end
      end else if (fl) begin
         if (!st) begin n_addr[DP-1] = m_addr[DP-2]; n_we[DP-1] = m_we[DP-2]; end
         for (int i = 0; i < DP-1; i++) begin n_addr[i] = 0; n_we[i] = 0; end
      end else if (!st) begin
         for (int i = DP-1; i > 0; i--) begin n_addr[i] = m_addr[i-1]; n_we[i] = m_we[i-1]; end
         n_addr[0] = e_addr;
         n_we[0]   = e_we;
      end
      for (int i = 0; i < DP; i++) begin m_addr[i] = n_addr[i]; m_we[i] = n_we[i]; end
      e.sa = '0; e.swe = '0; e.hz = 2'b00;
      for (int i = 0; i < DP; i++) begin
         e.sa[i*AW +: AW] = AW'(m_addr[i]);
         e.swe[i] = m_we[i];
         for (int k = 0; k < 2; k++)
            if (m_we[i] && (m_addr[i] == int'(qv[k*AW +: AW]))) e.hz[k] = 1'b1;
      end
      e.wa  = AW'(m_addr[DP-1]);
      e.wwe = m_we[DP-1];
      exp_q.push_back(e);
   endtask

   function automatic logic [NS*AW-1:0] srcs(input int a0, input int a1, input int a2);
      return {AW'(a2), AW'(a1), AW'(a0)};
   endfunction

   function automatic logic [2*AW-1:0] qry(input int q1, input int q0);
      return {AW'(q1), AW'(q0)};
   endfunction

   // Monitor: after every edge, compare the DUT against the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stage_addr", 32'(stage_addr), 32'(e.sa));
            chk("stage_we",   32'(stage_we),   32'(e.swe));
            chk("wb_addr",    32'(wb_addr),    32'(e.wa));
            chk("wb_we",      32'(wb_we),      32'(e.wwe));
            chk("hazard",     32'(hazard),     32'(e.hz));
         end
      end
   end

   initial begin
      logic [NS*AW-1:0] rsrc;
      for (int i = 0; i < DP; i++) begin m_addr[i] = 0; m_we[i] = 0; end
      rst = 1'b1; sel = '0; src_addr = '0; in_valid = 1'b0; reg_write = 1'b0;
      stall = 1'b0; flush = 1'b0; query_addr = '0;

      // Reset with random inputs.
      for (int i = 0; i < 2; i++)
         step(1, int'($urandom_range(0, 3)), NS*AW'($urandom), 1, 1,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2*AW'($urandom));

      // Select and latency: rd field, link, illegal select.
      step(0, 1, srcs(7, 12, 31), 1, 1, 0, 0, qry(12, 3));
      step(0, 0, '0, 0, 0, 0, 0, qry(12, 3));
      step(0, 0, '0, 0, 0, 0, 0, qry(12, 3));
      step(0, 2, srcs(7, 12, 31), 1, 1, 0, 0, qry(31, 0));
      step(0, 3, srcs(7, 12, 31), 1, 1, 0, 0, qry(31, 0));
      step(0, 0, '0, 0, 0, 0, 0, qry(31, 0));
      step(0, 0, '0, 0, 0, 0, 0, qry(31, 0));

      // Register zero is never written; query 0 does not hit.
      step(0, 0, srcs(0, 4, 5), 1, 1, 0, 0, qry(0, 0));
      step(0, 0, '0, 0, 0, 0, 0, qry(0, 0));
      step(0, 0, '0, 0, 0, 0, 0, qry(0, 0));

      // Stall with entry 9 in stage 1; input offered during the stall is ignored.
      step(0, 0, srcs(9, 0, 0), 1, 1, 0, 0, qry(0, 9));
      step(0, 0, srcs(0, 0, 0), 0, 0, 0, 0, qry(0, 9));
      step(0, 1, srcs(0, 17, 0), 1, 1, 1, 0, qry(17, 9));
      step(0, 1, srcs(0, 18, 0), 1, 1, 1, 0, qry(18, 9));
      step(0, 0, '0, 0, 0, 0, 0, qry(0, 9));
      step(0, 0, '0, 0, 0, 0, 0, qry(0, 9));

      // Flush with 5,6,7 in stages 0,1,2.
      step(0, 0, srcs(7, 0, 0), 1, 1, 0, 0, '0);
      step(0, 0, srcs(6, 0, 0), 1, 1, 0, 0, '0);
      step(0, 0, srcs(5, 0, 0), 1, 1, 0, 0, '0);
      step(0, 0, srcs(20, 0, 0), 1, 1, 0, 1, qry(6, 5));
      step(0, 0, '0, 0, 0, 0, 0, qry(6, 5));

      // Hazard: addr 8 live in stage 1, then the same address without a write.
      step(0, 1, srcs(0, 8, 0), 1, 1, 0, 0, qry(8, 3));
      step(0, 0, '0, 0, 0, 0, 0, qry(8, 3));
      step(0, 1, srcs(0, 8, 0), 1, 0, 0, 0, qry(8, 3));
      step(0, 0, '0, 0, 0, 0, 0, qry(8, 3));

      // Flush during stall, and reset mid-stream.
      step(0, 0, srcs(11, 0, 0), 1, 1, 0, 0, '0);
      step(0, 0, srcs(13, 0, 0), 1, 1, 0, 0, '0);
      step(0, 0, srcs(14, 0, 0), 1, 1, 1, 1, qry(13, 11));
      step(0, 0, srcs(15, 0, 0), 1, 1, 0, 0, qry(15, 11));
      step(1, 0, srcs(16, 0, 0), 1, 1, 0, 0, qry(15, 11));

      // Random traffic with small addresses so hazards occur often.
      for (int n = 0; n < 1500; n++) begin
         for (int f = 0; f < NS; f++)
            rsrc[f*AW +: AW] = ($urandom_range(0, 9) == 0) ? AW'(31) : AW'($urandom_range(0, 7));
         step($urandom_range(0, 49) == 0, int'($urandom_range(0, 3)), rsrc,
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
              qry(int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
      end

      repeat (3) @(posedge clk);
      #2;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
